// File: rtl/cpu_multicycle_ctrl_pkg.sv
// ------------------------------------------------------------------
// cpu_ctrl_pkg : state, opcode and select encodings shared by the
// multicycle controller files.                          Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package cpu_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_R_EXEC    = 4'd6,
      S_R_WB      = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9,
      S_I_EXEC    = 4'd10,
      S_I_WB      = 4'd11,
      S_IDLE      = 4'd12,
      S_HALT      = 4'd13
   } state_t;

   localparam logic [5:0] OP_LI      = 6'b010000;
   localparam logic [5:0] OP_SWI     = 6'b010001;
   localparam logic [5:0] OP_BEQ     = 6'b100000;
   localparam logic [5:0] OP_JMP     = 6'b100001;
   localparam logic [2:0] OP_R_CLASS = 3'b000;
   localparam logic [2:0] OP_I_CLASS = 3'b001;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b011;

   localparam logic [1:0] SRCB_REGB  = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_SEXT  = 2'b10;
   localparam logic [1:0] SRCB_SHIFT = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_write_cond;
      logic       pc_write;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       ir_write;
      logic       r1_or_r3;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_op;
      logic [1:0] pc_source;
      logic       halted;
   } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/cpu_multicycle_ctrl_if.sv
// ------------------------------------------------------------------
// cpu_ctrl_if : controller <-> datapath control bundle.
// CPU_CTRL_MEM_WAIT_EN adds the MemReady handshake.     Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface cpu_ctrl_if #(
   parameter int CNT_W = 16
);
   logic [5:0]       Opcode;
   logic             PCWriteCond;
   logic             PCWrite;
   logic             MemRead;
   logic             MemWrite;
   logic             MemtoReg;
   logic             IRWrite;
   logic             R1orR3;
   logic             RegWrite;
   logic             ALUSrcA;
   logic [1:0]       ALUSrcB;
   logic [2:0]       ALUOp;
   logic [1:0]       PCSource;
   logic [3:0]       State;
   logic             Halted;
   logic             IllegalOp;
   logic [CNT_W-1:0] InstrCount;
`ifdef CPU_CTRL_MEM_WAIT_EN
   logic             MemReady;

   modport master (
      input  Opcode, MemReady,
      output PCWriteCond, PCWrite, MemRead, MemWrite, MemtoReg, IRWrite,
             R1orR3, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
             State, Halted, IllegalOp, InstrCount
   );
   modport slave (
      output Opcode, MemReady,
      input  PCWriteCond, PCWrite, MemRead, MemWrite, MemtoReg, IRWrite,
             R1orR3, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
             State, Halted, IllegalOp, InstrCount
   );
`else
   modport master (
      input  Opcode,
      output PCWriteCond, PCWrite, MemRead, MemWrite, MemtoReg, IRWrite,
             R1orR3, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
             State, Halted, IllegalOp, InstrCount
   );
   modport slave (
      output Opcode,
      input  PCWriteCond, PCWrite, MemRead, MemWrite, MemtoReg, IRWrite,
             R1orR3, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
             State, Halted, IllegalOp, InstrCount
   );
`endif
endinterface

`default_nettype wire

// File: rtl/cpu_multicycle_ctrl_decode.sv
// ------------------------------------------------------------------
// cpu_ctrl_decode : Moore output decode, state + latched op -> controls.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module cpu_ctrl_decode
   import cpu_ctrl_pkg::*;
(
   input  state_t     state,
   input  logic [2:0] alu_fn,
   input  logic       mem_ready,
   output ctrl_t      ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            // Strobes that commit the fetch are held off until memory answers.
            ctrl.pc_write  = mem_ready;
            ctrl.mem_read  = 1'b1;
            ctrl.ir_write  = mem_ready;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_op    = ALU_ADD;
            ctrl.pc_source = PCSRC_ALU;
         end
         S_DECODE: begin
            ctrl.alu_src_b = SRCB_SHIFT;
            ctrl.alu_op    = ALU_ADD;
         end
         S_MEM_ADDR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_SEXT;
            ctrl.alu_op    = ALU_ADD;
         end
         S_MEM_READ: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_SEXT;
            ctrl.alu_op    = ALU_ADD;
         end
         S_MEM_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         S_MEM_WRITE: begin
            ctrl.mem_write = mem_ready;
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_SEXT;
            ctrl.alu_op    = ALU_ADD;
         end
         S_R_EXEC, S_R_WB: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_REGB;
            ctrl.alu_op    = alu_fn;
            ctrl.reg_write = (state == S_R_WB);
            ctrl.r1_or_r3  = (state == S_R_WB);
         end
         S_BRANCH: begin
            ctrl.pc_write_cond = 1'b1;
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_src_b     = SRCB_REGB;
            ctrl.alu_op        = ALU_SUB;
            ctrl.pc_source     = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PCSRC_JUMP;
         end
         S_I_EXEC, S_I_WB: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_SEXT;
            ctrl.alu_op    = alu_fn;
            ctrl.reg_write = (state == S_I_WB);
         end
         S_HALT: ctrl.halted = 1'b1;
         default: ctrl = '0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/cpu_multicycle_ctrl.sv
// ------------------------------------------------------------------
// cpu_multicycle_ctrl : multicycle control FSM sequencing CPU_Datapath.
// Macro CPU_CTRL_MEM_WAIT_EN adds MemReady stalls.      Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module cpu_multicycle_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int         CNT_W   = 16,
   parameter logic [5:0] HALT_OP = 6'b111111
) (
   input  logic      Clk,
   input  logic      Reset,
   cpu_ctrl_if.master bus
);

   state_t           state_q, state_d;
   logic [5:0]       op_q, op_d;
   logic             illegal_q, illegal_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             retire;
   logic             mem_ready;
   ctrl_t            ctrl;

`ifdef CPU_CTRL_MEM_WAIT_EN
   assign mem_ready = bus.MemReady;
`else
   assign mem_ready = 1'b1;
`endif

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      illegal_d = illegal_q;
      retire    = 1'b0;
      case (state_q)
         S_IDLE:  state_d = S_FETCH;
         S_FETCH: if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            op_d = bus.Opcode;
            if (bus.Opcode == HALT_OP) begin
               state_d = S_HALT;
               retire  = 1'b1;
            end else if (bus.Opcode[5:3] == OP_R_CLASS) begin
               state_d = S_R_EXEC;
            end else if (bus.Opcode[5:3] == OP_I_CLASS) begin
               state_d = S_I_EXEC;
            end else if (bus.Opcode == OP_LI || bus.Opcode == OP_SWI) begin
               state_d = S_MEM_ADDR;
            end else if (bus.Opcode == OP_BEQ) begin
               state_d = S_BRANCH;
            end else if (bus.Opcode == OP_JMP) begin
               state_d = S_JUMP;
            end else begin
               state_d   = S_FETCH;
               illegal_d = 1'b1;
            end
         end
         S_MEM_ADDR: state_d = (op_q == OP_LI) ? S_MEM_READ : S_MEM_WRITE;
         S_MEM_READ: if (mem_ready) state_d = S_MEM_WB;
         S_MEM_WRITE: begin
            if (mem_ready) begin
               state_d = S_FETCH;
               retire  = 1'b1;
            end
         end
         S_R_EXEC: state_d = S_R_WB;
         S_I_EXEC: state_d = S_I_WB;
         S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
      cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         illegal_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         illegal_q <= illegal_d;
         cnt_q     <= cnt_d;
      end
   end

   cpu_ctrl_decode u_decode (
      .state     (state_q),
      .alu_fn    (op_q[2:0]),
      .mem_ready (mem_ready),
      .ctrl      (ctrl)
   );

   assign bus.PCWriteCond = ctrl.pc_write_cond;
   assign bus.PCWrite     = ctrl.pc_write;
   assign bus.MemRead     = ctrl.mem_read;
   assign bus.MemWrite    = ctrl.mem_write;
   assign bus.MemtoReg    = ctrl.mem_to_reg;
   assign bus.IRWrite     = ctrl.ir_write;
   assign bus.R1orR3      = ctrl.r1_or_r3;
   assign bus.RegWrite    = ctrl.reg_write;
   assign bus.ALUSrcA     = ctrl.alu_src_a;
   assign bus.ALUSrcB     = ctrl.alu_src_b;
   assign bus.ALUOp       = ctrl.alu_op;
   assign bus.PCSource    = ctrl.pc_source;
   assign bus.Halted      = ctrl.halted;
   assign bus.State       = state_q;
   assign bus.IllegalOp   = illegal_q;
   assign bus.InstrCount  = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_multicycle_ctrl.sv
// ------------------------------------------------------------------
// tb_cpu_multicycle_ctrl : directed + random opcode bench with a
// per-instruction state-path reference model.           Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_cpu_multicycle_ctrl;

   logic Clk = 1'b0;
   logic Reset;
   int   total = 0;
   int   bad   = 0;

   cpu_ctrl_if #(.CNT_W(16)) bus ();

   cpu_multicycle_ctrl #(.CNT_W(16), .HALT_OP(6'b111111)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic       pcwc, pcw, mr, mw, m2r, irw, r13, rw, sa;
      logic [1:0] sb;
      logic [2:0] aop;
      logic [1:0] pcs;
      logic       h;
   } cv_t;

   logic [15:0] exp_cnt;
   logic        exp_ill;
   int          path[$];

   function automatic cv_t obs_cv();
      cv_t c;
      c = {bus.PCWriteCond, bus.PCWrite, bus.MemRead, bus.MemWrite, bus.MemtoReg,
           bus.IRWrite, bus.R1orR3, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB,
           bus.ALUOp, bus.PCSource, bus.Halted};
      return c;
   endfunction

   // Control table written straight from the per-state output list.
   function automatic cv_t ref_cv(int st, logic [5:0] op);
      cv_t c = '0;
      case (st)
         0:  begin c.pcw = 1; c.mr = 1; c.irw = 1; c.sb = 2'b01; c.aop = 3'b010; end
         1:  begin c.sb = 2'b11; c.aop = 3'b010; end
         2:  begin c.sa = 1; c.sb = 2'b10; c.aop = 3'b010; end
         3:  begin c.mr = 1; c.sa = 1; c.sb = 2'b10; c.aop = 3'b010; end
         4:  begin c.rw = 1; c.m2r = 1; end
         5:  begin c.mw = 1; c.sa = 1; c.sb = 2'b10; c.aop = 3'b010; end
         6:  begin c.sa = 1; c.aop = op[2:0]; end
         7:  begin c.sa = 1; c.aop = op[2:0]; c.rw = 1; c.r13 = 1; end
         8:  begin c.pcwc = 1; c.sa = 1; c.aop = 3'b011; c.pcs = 2'b01; end
         9:  begin c.pcw = 1; c.pcs = 2'b10; end
         10: begin c.sa = 1; c.sb = 2'b10; c.aop = op[2:0]; end
         11: begin c.sa = 1; c.sb = 2'b10; c.aop = op[2:0]; c.rw = 1; end
         13: c.h = 1;
         default: c = '0;
      endcase
      return c;
   endfunction

   function automatic bit is_legal(logic [5:0] op);
      return (op[5:4] == 2'b00) || op == 6'd16 || op == 6'd17 ||
             op == 6'd32 || op == 6'd33 || op == 6'd63;
   endfunction

   // Sequence of states an instruction visits, from FETCH up to retirement.
   function automatic void build_path(logic [5:0] op);
      path = {0, 1};
      if (op[5:3] == 3'b000)      path = {0, 1, 6, 7};
      else if (op[5:3] == 3'b001) path = {0, 1, 10, 11};
      else if (op == 6'd16)       path = {0, 1, 2, 3, 4};
      else if (op == 6'd17)       path = {0, 1, 2, 5};
      else if (op == 6'd32)       path = {0, 1, 8};
      else if (op == 6'd33)       path = {0, 1, 9};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic run_instr(input logic [5:0] op);
      build_path(op);
      bus.Opcode = op;
      for (int i = 0; i < path.size(); i++) begin
         // After DECODE the opcode bus is free to change; outputs must not follow it.
         if (i >= 2) bus.Opcode = 6'($urandom);
         chk($sformatf("state[%0h/%0d]", op, i), 32'(bus.State), 32'(path[i]));
         chk($sformatf("ctrl[%0h/%0d]", op, i), 32'(obs_cv()), 32'(ref_cv(path[i], op)));
         tick();
      end
      if (is_legal(op)) exp_cnt = exp_cnt + 16'd1;
      else              exp_ill = 1'b1;
      chk("back_to_fetch", 32'(bus.State), 32'd0);
      chk("instr_count", 32'(bus.InstrCount), 32'(exp_cnt));
      chk("illegal_op", 32'(bus.IllegalOp), 32'(exp_ill));
   endtask

   function automatic logic [5:0] rand_op();
      logic [5:0] op;
      case ($urandom_range(0, 6))
         0:       op = {3'b000, 3'($urandom)};
         1:       op = {3'b001, 3'($urandom)};
         2:       op = 6'd16;
         3:       op = 6'd17;
         4:       op = 6'd32;
         5:       op = 6'd33;
         default: begin
            op = 6'($urandom);
            for (int k = 0; k < 64 && is_legal(op); k++) op = op + 6'd1;
         end
      endcase
      return op;
   endfunction

   initial begin
      Reset      = 1'b0;
      bus.Opcode = 6'd0;
`ifdef CPU_CTRL_MEM_WAIT_EN
      bus.MemReady = 1'b1;
`endif
      exp_cnt = '0;
      exp_ill = 1'b0;

      repeat (3) begin
         tick();
         chk("rst_state", 32'(bus.State), 32'd12);
         chk("rst_ctrl", 32'(obs_cv()), 32'd0);
         chk("rst_count", 32'(bus.InstrCount), 32'd0);
         chk("rst_illegal", 32'(bus.IllegalOp), 32'd0);
      end
      Reset = 1'b1;
      tick();

      run_instr(6'b010000);
      run_instr(6'b000110);
      run_instr(6'b100000);
      run_instr(6'b011111);
      run_instr(6'b010001);
      run_instr(6'b100001);
      run_instr(6'b001101);

`ifdef CPU_CTRL_MEM_WAIT_EN
      bus.MemReady = 1'b0;
      repeat (3) begin
         chk("wait_state", 32'(bus.State), 32'd0);
         chk("wait_irwrite", 32'(bus.IRWrite), 32'd0);
         chk("wait_pcwrite", 32'(bus.PCWrite), 32'd0);
         chk("wait_memread", 32'(bus.MemRead), 32'd1);
         tick();
      end
      bus.MemReady = 1'b1;
      #1;
      chk("wait_release_irwrite", 32'(bus.IRWrite), 32'd1);
      run_instr(6'b010001);
`endif

      for (int n = 0; n < 40; n++) run_instr(rand_op());

      // Asynchronous reset dropped in the middle of a load.
      bus.Opcode = 6'b010000;
      repeat (3) tick();
      chk("pre_rst_state", 32'(bus.State), 32'd3);
      #3 Reset = 1'b0;
      #1;
      chk("async_rst_state", 32'(bus.State), 32'd12);
      chk("async_rst_memread", 32'(bus.MemRead), 32'd0);
      chk("async_rst_count", 32'(bus.InstrCount), 32'd0);
      exp_cnt = '0;
      exp_ill = 1'b0;
      Reset = 1'b1;
      tick();
      run_instr(6'b000011);

      bus.Opcode = 6'b111111;
      tick();
      chk("halt_decode", 32'(bus.State), 32'd1);
      tick();
      exp_cnt = exp_cnt + 16'd1;
      repeat (20) begin
         chk("halt_state", 32'(bus.State), 32'd13);
         chk("halt_ctrl", 32'(obs_cv()), 32'(ref_cv(13, 6'd63)));
         chk("halt_count", 32'(bus.InstrCount), 32'(exp_cnt));
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/cpu_multicycle_ctrl.md
Name: cpu_multicycle_ctrl

Overview:
- Multicycle control FSM that sequences CPU_Datapath. It replaces hand-driven control stimulus.
- Consumes the datapath's 6-bit Out_to_Control opcode and drives every datapath control input, one state per cycle.
- Provides halt, illegal-opcode and retired-instruction status for the top level and benches.

Parameters:
- CNT_W, 16, width of retired-instruction counter InstrCount.
- HALT_OP, 6'b111111, opcode that enters HALT.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
- Opcode  input  6  Out_to_Control from the datapath; valid from DECODE onward.
- PCWriteCond  output  1  conditional PC write (branch).
- PCWrite  output  1  unconditional PC write.
- MemRead  output  1  memory read enable.
- MemWrite  output  1  memory write enable.
- MemtoReg  output  1  register write data: 1 = memory data, 0 = ALUOut.
- IRWrite  output  1  instruction register load.
- R1orR3  output  1  destination select: 0 = R1 [25:21], 1 = R3 [15:11].
- RegWrite  output  1  register file write.
- ALUSrcA  output  1  0 = PC, 1 = reg A.
- ALUSrcB  output  2  00 = reg B, 01 = const 4, 10 = sign-extended immediate, 11 = shifted immediate.
- ALUOp  output  3  ALU function.
- PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- State  output  4  current state encoding, for debug.
- Halted  output  1  high while in HALT.
- IllegalOp  output  1  sticky flag: an undefined opcode was decoded.
- InstrCount  output  CNT_W  count of instructions retired.

Behaviour:
- Moore FSM. Outputs decode combinationally from the state register and op_q. The state register and counters reset asynchronously on Reset=0.
- Reset values: State=IDLE(4'd12), all control outputs 0, Halted=0, IllegalOp=0, InstrCount=0, op_q=0.
- Reset asserted mid-instruction forces IDLE immediately, without waiting for a clock edge. The partial instruction is not counted.
- IDLE: all outputs 0. Goes to FETCH on the next edge.
- FETCH(0): PCWrite=1, MemRead=1, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=010, PCSource=00. Goes to DECODE.
- DECODE(1): ALUSrcB=11, ALUOp=010, all write enables 0. Latches op_q<=Opcode and branches on Opcode:
  - 000xxx -> R_EXEC
  - 001xxx -> I_EXEC
  - 010000 (LI/LWI) -> MEM_ADDR
  - 010001 (SWI) -> MEM_ADDR
  - 100000 (BEQ) -> BRANCH
  - 100001 (JMP) -> JUMP
  - HALT_OP -> HALT
  - anything else -> FETCH, with IllegalOp set and InstrCount not incremented.
- MEM_ADDR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=010. Goes to MEM_READ if op_q=010000, else MEM_WRITE.
- MEM_READ(3): MEM_ADDR's ALU settings plus MemRead=1. Goes to MEM_WB.
- MEM_WB(4): RegWrite=1, MemtoReg=1, R1orR3=0. Retires, goes to FETCH.
- MEM_WRITE(5): MemWrite=1, ALUSrcA=1, ALUSrcB=10, ALUOp=010. Retires, goes to FETCH.
- R_EXEC(6): ALUSrcA=1, ALUSrcB=00, ALUOp=op_q[2:0]. Goes to R_WB.
- R_WB(7): R_EXEC's ALU settings plus RegWrite=1, R1orR3=1. Retires.
- BRANCH(8): PCWriteCond=1, ALUSrcA=1, ALUSrcB=00, ALUOp=011, PCSource=01. Retires.
- JUMP(9): PCWrite=1, PCSource=10. Retires.
- I_EXEC(10): ALUSrcA=1, ALUSrcB=10, ALUOp=op_q[2:0]. Goes to I_WB.
- I_WB(11): I_EXEC's ALU settings plus RegWrite=1, R1orR3=0. Retires.
- HALT(13): all control outputs 0, Halted=1. Self-loops until reset. Counts as retired on entry.
- Retire: InstrCount increments on each edge that enters FETCH from a retiring state, or that enters HALT. It wraps modulo 2^CNT_W.
- Unused state codes 14, 15 -> IDLE on the next edge.
- PCWrite and PCWriteCond are never both 1. MemRead and MemWrite are never both 1.

Optional Feature:
- Macro CPU_CTRL_MEM_WAIT_EN adds input MemReady (1 bit).
- With the macro:
  - FETCH, MEM_READ and MEM_WRITE hold while MemReady=0.
  - During the hold, PCWrite, IRWrite and MemWrite are gated to 0. MemRead stays 1.
  - The state advances, with full strobes, on the first cycle MemReady=1.
- Without the macro: no port; every state lasts exactly one cycle.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - state encodings
  - opcode constants (OP_LI, OP_SWI, OP_BEQ, OP_JMP, class prefixes)
  - ALUOp codes (ALU_ADD=010, ALU_SUB=011)
  - ALUSrcB and PCSource select codes.
- One sub-module, cpu_ctrl_decode: combinational state/op_q -> control-vector decode. The FSM core owns the registers.

Test Plan:
- Hold Reset=0 across edges -> all outputs 0, State=12. Release -> next edge State=0 with PCWrite=1, MemRead=1, IRWrite=1, ALUSrcB=01, ALUOp=010.
- Opcode=010000 -> States 0,1,2,3,4,0. In state 4, RegWrite=1 and MemtoReg=1. InstrCount 0->1.
- Opcode=000110 -> States 0,1,6,7,0. ALUOp=110 in 6 and 7. In 7, RegWrite=1 and R1orR3=1. Change Opcode in state 6 -> ALUOp unchanged.
- Opcode=100000 -> States 0,1,8,0. In 8, PCWriteCond=1, ALUOp=011, PCSource=01.
- Opcode=011111 -> returns to 0 after DECODE, IllegalOp=1 stays set, InstrCount unchanged. Opcode=111111 -> State=13, Halted=1 held 20 cycles.
- Drop Reset mid-cycle in state 3 -> State=12 and MemRead=0 before the next edge. With CPU_CTRL_MEM_WAIT_EN and MemReady=0 for 3 cycles in FETCH -> State stays 0, IRWrite=0 until MemReady=1.
